// File: rtl/hdmi_capture_pkg.sv
// Shared definitions for the HDMI capture sequencer: state encoding and default geometry.
package hdmi_capture_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_VSYNC = 2'd1,
    CAPTURE    = 2'd2,
    ERROR      = 2'd3
  } captureState_t;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_CNT_W    = 12;

  // Per-cycle sync events seen by the sequencer.
  typedef struct packed {
    logic vsTrail;
    logic deFall;
  } syncEvents_t;

endpackage

// File: rtl/sync_edge_detect.sv
// One-register edge detector; o_trailEdge fires on the cycle the input leaves level POL.
module sync_edge_detect #(
  parameter logic POL = 1'b1
) (
  input  logic i_hdmiClock,
  input  logic i_reset,
  input  logic i_sig,
  output logic o_trailEdge
);

  logic r_prev;

  always_ff @(posedge i_hdmiClock or posedge i_reset) begin
    if (i_reset) r_prev <= 1'b0;
    else         r_prev <= i_sig;
  end

  assign o_trailEdge = (r_prev == POL) && (i_sig != POL);

endmodule

// File: rtl/hdmi_capture_ctrl.sv
// Frame-level sequencer for the TFP401 capture path; gates the ingester to whole frames.
// Optional statistics outputs are enabled with `define HDMI_CAPTURE_STATS_EN.
module hdmi_capture_ctrl
  import hdmi_capture_pkg::*;
#(
  parameter int   H_ACTIVE  = DEF_H_ACTIVE,
  parameter int   V_ACTIVE  = DEF_V_ACTIVE,
  parameter int   CNT_W     = DEF_CNT_W,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic             i_hdmiClock,
  input  logic             i_reset,
  input  logic             i_captureEnable,
  input  logic             i_vSync,
  input  logic             i_hSync,
  input  logic             i_de,
  input  logic             i_fifoFull,
  input  logic             i_dataValid,
  output logic             o_hdmiEnable,
  output logic             o_fifoFlush,
  output logic             o_frameActive,
  output logic             o_frameDone,
  output logic             o_overflow,
  output logic             o_lineError,
  output logic [CNT_W-1:0] o_lineCount
`ifdef HDMI_CAPTURE_STATS_EN
  ,
  output logic [15:0]      o_frameCount,
  output logic [15:0]      o_droppedFrames,
  output logic [CNT_W-1:0] o_hSyncPerFrame
`endif
);

  localparam logic [CNT_W-1:0] LINE_LEN  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(V_ACTIVE - 1);

  captureState_t    state, stateNext;
  syncEvents_t      ev;
  logic [CNT_W-1:0] pixelCount;
  logic             r_enablePrev;

  logic startFrame, abortFrame, lineEnd, frameEnd, overflowHit, flushReq;

  sync_edge_detect #(.POL(VSYNC_POL)) uVsEdge (
    .i_hdmiClock (i_hdmiClock),
    .i_reset     (i_reset),
    .i_sig       (i_vSync),
    .o_trailEdge (ev.vsTrail)
  );

  sync_edge_detect #(.POL(1'b1)) uDeEdge (
    .i_hdmiClock (i_hdmiClock),
    .i_reset     (i_reset),
    .i_sig       (i_de),
    .o_trailEdge (ev.deFall)
  );

  always_ff @(posedge i_hdmiClock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= stateNext;
  end

  // Overflow outranks an early vSync and the final line end in the same cycle.
  always_comb begin
    stateNext   = state;
    startFrame  = 1'b0;
    abortFrame  = 1'b0;
    lineEnd     = 1'b0;
    frameEnd    = 1'b0;
    overflowHit = 1'b0;
    flushReq    = 1'b0;
    case (state)
      IDLE: begin
        if (i_captureEnable) stateNext = WAIT_VSYNC;
      end
      WAIT_VSYNC: begin
        if (!i_captureEnable) stateNext = IDLE;
        else if (ev.vsTrail) begin
          stateNext  = CAPTURE;
          startFrame = 1'b1;
        end
      end
      CAPTURE: begin
        if (i_fifoFull && i_dataValid) begin
          overflowHit = 1'b1;
          stateNext   = ERROR;
        end else if (ev.vsTrail) begin
          // Short frame: the edge itself starts the next frame.
          abortFrame = 1'b1;
          flushReq   = 1'b1;
          startFrame = 1'b1;
        end else if (ev.deFall) begin
          lineEnd = 1'b1;
          if (o_lineCount == LAST_LINE) begin
            frameEnd  = 1'b1;
            stateNext = i_captureEnable ? WAIT_VSYNC : IDLE;
          end
        end
      end
      ERROR: begin
        if (ev.vsTrail) begin
          flushReq  = 1'b1;
          stateNext = i_captureEnable ? WAIT_VSYNC : IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge i_hdmiClock or posedge i_reset) begin
    if (i_reset) begin
      r_enablePrev  <= 1'b0;
      o_hdmiEnable  <= 1'b0;
      o_frameActive <= 1'b0;
      o_frameDone   <= 1'b0;
      o_fifoFlush   <= 1'b0;
      o_overflow    <= 1'b0;
      o_lineError   <= 1'b0;
      o_lineCount   <= '0;
      pixelCount    <= '0;
    end else begin
      r_enablePrev  <= i_captureEnable;
      o_hdmiEnable  <= (stateNext == CAPTURE);
      o_frameActive <= (stateNext == CAPTURE);
      o_frameDone   <= frameEnd;
      o_fifoFlush   <= flushReq;

      if (startFrame) begin
        pixelCount  <= '0;
        o_lineCount <= '0;
      end else if (state == CAPTURE) begin
        if (lineEnd) begin
          pixelCount  <= '0;
          o_lineCount <= o_lineCount + 1'b1;
        end else if (i_de && (pixelCount != '1)) begin
          pixelCount <= pixelCount + 1'b1;
        end
      end

      // Sticky flags: cleared by a fresh enable, a same-cycle set takes priority.
      if (i_captureEnable && !r_enablePrev) begin
        o_overflow  <= 1'b0;
        o_lineError <= 1'b0;
      end
      if (overflowHit) o_overflow <= 1'b1;
      if (abortFrame || (lineEnd && (pixelCount != LINE_LEN))) o_lineError <= 1'b1;
    end
  end

`ifdef HDMI_CAPTURE_STATS_EN
  logic             hsRise;
  logic [CNT_W-1:0] hsCount;

  // Trailing edge of an active-low view is the rising edge.
  sync_edge_detect #(.POL(1'b0)) uHsEdge (
    .i_hdmiClock (i_hdmiClock),
    .i_reset     (i_reset),
    .i_sig       (i_hSync),
    .o_trailEdge (hsRise)
  );

  always_ff @(posedge i_hdmiClock or posedge i_reset) begin
    if (i_reset) begin
      o_frameCount    <= '0;
      o_droppedFrames <= '0;
      o_hSyncPerFrame <= '0;
      hsCount         <= '0;
    end else begin
      if (frameEnd) begin
        o_frameCount    <= o_frameCount + 1'b1;
        o_hSyncPerFrame <= hsCount + CNT_W'(hsRise);
      end
      if ((overflowHit || abortFrame) && (o_droppedFrames != '1))
        o_droppedFrames <= o_droppedFrames + 1'b1;
      if (startFrame)                    hsCount <= '0;
      else if (state == CAPTURE && hsRise) hsCount <= hsCount + 1'b1;
    end
  end
`else
  logic unusedHSync;
  assign unusedHSync = i_hSync;
`endif

endmodule

// File: tb/tb_hdmi_capture_ctrl.sv
// Directed and randomized frame stimulus for hdmi_capture_ctrl, checked against frame-level expectations.
module tb_hdmi_capture_ctrl;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int CW = 12;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, vs = 1'b1, hs = 1'b0, de = 1'b0;
  logic full = 1'b0, valid = 1'b0;
  logic hdmiEn, flush, active, done, ovf, lerr;
  logic [CW-1:0] lcnt;

  int errors = 0;
  int checks = 0;
  int doneCnt = 0;
  int flushCnt = 0;

  hdmi_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(CW), .VSYNC_POL(1'b0)) dut (
    .i_hdmiClock     (clk),
    .i_reset         (rst),
    .i_captureEnable (en),
    .i_vSync         (vs),
    .i_hSync         (hs),
    .i_de            (de),
    .i_fifoFull      (full),
    .i_dataValid     (valid),
    .o_hdmiEnable    (hdmiEn),
    .o_fifoFlush     (flush),
    .o_frameActive   (active),
    .o_frameDone     (done),
    .o_overflow      (ovf),
    .o_lineError     (lerr),
    .o_lineCount     (lcnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done)  doneCnt++;
    if (flush) flushCnt++;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not end, observed timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // vSync active (low) for two cycles; returns just after the trailing-edge clock.
  task automatic vsyncPulse();
    vs = 1'b0;
    tick(2);
    vs = 1'b1;
    tick();
  endtask

  // DE high for len pixels, optional overflow on pixel ovfAt; returns after the DE-fall clock.
  task automatic sendLine(input int len, input int ovfAt, output logic enAfterOvf);
    enAfterOvf = 1'b1;
    for (int i = 0; i < len; i++) begin
      de = 1'b1;
      if (i == ovfAt) begin full = 1'b1; valid = 1'b1; end
      tick();
      if (i == ovfAt) begin
        full = 1'b0; valid = 1'b0;
        enAfterOvf = hdmiEn;
      end
    end
    de = 1'b0;
    tick();
  endtask

  task automatic gap();
    hs = 1'b1;
    tick();
    hs = 1'b0;
    tick($urandom_range(1, 3));
  endtask

  task automatic reEnable();
    en = 1'b0;
    tick(2);
    en = 1'b1;
    tick(2);
  endtask

  initial begin
    logic eo;
    int   d0, f0, ovfLine, len, ovfAt;
    logic expErr, expOvf;

    tick(3);
    check("rst_outputs", {hdmiEn, flush, active, done, ovf, lerr}, 6'b0);
    check("rst_lineCount", lcnt, 0);
    rst = 1'b0;
    tick(2);

    // Clean 4x2 frame
    en = 1'b1;
    tick(3);
    check("t1_enable_before_vsync", hdmiEn, 0);
    vsyncPulse();
    check("t1_enable_after_edge", {hdmiEn, active}, 2'b11);
    sendLine(H, -1, eo);
    check("t1_lineCount1", lcnt, 1);
    check("t1_noDoneYet", done, 0);
    gap();
    sendLine(H, -1, eo);
    check("t1_frameDone", done, 1);
    check("t1_lineCount2", lcnt, 2);
    check("t1_enableDropped", {hdmiEn, active}, 2'b00);
    tick();
    check("t1_donePulseWidth", done, 0);
    gap();

    // Long line sets the sticky line error, frame still completes
    vsyncPulse();
    check("t2_capture", hdmiEn, 1);
    check("t2_countersCleared", lcnt, 0);
    sendLine(H + 1, -1, eo);
    check("t2_lineError", lerr, 1);
    gap();
    sendLine(H, -1, eo);
    check("t2_frameDone", done, 1);
    tick();
    check("t2_lineErrorHeld", lerr, 1);
    reEnable();
    check("t2_stickyCleared", lerr, 0);

    // FIFO overflow on line 1
    d0 = doneCnt; f0 = flushCnt;
    vsyncPulse();
    sendLine(H, 1, eo);
    check("t3_enableDropNextCycle", eo, 0);
    check("t3_overflow", ovf, 1);
    gap();
    sendLine(H, -1, eo);
    gap();
    check("t3_noFrameDone", doneCnt, d0);
    check("t3_noFlushYet", flushCnt, f0);
    vsyncPulse();
    check("t3_flushPulse", flush, 1);
    tick();
    check("t3_flushPulseWidth", flush, 0);
    check("t3_flushCount", flushCnt, f0 + 1);
    check("t3_waitVsync", hdmiEn, 0);
    vsyncPulse();
    check("t3_recapture", hdmiEn, 1);
    sendLine(H, -1, eo);
    gap();
    sendLine(H, -1, eo);
    check("t3_cleanFrameDone", done, 1);
    check("t3_overflowSticky", ovf, 1);
    gap();

    // Enable dropped mid-frame: frame finishes, then idle
    d0 = doneCnt;
    vsyncPulse();
    sendLine(H, -1, eo);
    gap();
    en = 1'b0;
    sendLine(H, -1, eo);
    check("t4_frameDone", done, 1);
    tick();
    check("t4_idleOutputs", {hdmiEn, active}, 2'b00);
    gap();
    vsyncPulse();
    check("t4_idleIgnoresVsync", hdmiEn, 0);
    check("t4_doneCount", doneCnt, d0 + 1);
    check("t4_overflowHeld", ovf, 1);

    // Asynchronous reset mid-capture
    en = 1'b1;
    tick(2);
    check("t5_enableRiseClears", ovf, 0);
    vsyncPulse();
    sendLine(H, -1, eo);
    gap();
    de = 1'b1;
    tick(2);
    #2 rst = 1'b1;
    #1;
    check("t5_asyncOutputs", {hdmiEn, flush, active, done, ovf, lerr}, 6'b0);
    check("t5_asyncLineCount", lcnt, 0);
    tick(2);
    de = 1'b0;
    rst = 1'b0;
    tick(2);
    check("t5_idleAfterRelease", {hdmiEn, active}, 2'b00);

    // Early vSync at line 1 restarts capture directly
    vsyncPulse();
    check("t6_capture", hdmiEn, 1);
    sendLine(H, -1, eo);
    check("t6_lineCount1", lcnt, 1);
    gap();
    vsyncPulse();
    check("t6_lineError", lerr, 1);
    check("t6_flushPulse", flush, 1);
    check("t6_countersCleared", lcnt, 0);
    check("t6_stillCapturing", hdmiEn, 1);
    sendLine(H, -1, eo);
    gap();
    sendLine(H, -1, eo);
    check("t6_frameDone", done, 1);
    check("t6_lineCount2", lcnt, 2);
    gap();

    // Randomized frames against frame-level expectations
    reEnable();
    expErr = 1'b0;
    expOvf = 1'b0;
    for (int fr = 0; fr < 10; fr++) begin
      ovfLine = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, V - 1)) : -1;
      d0 = doneCnt; f0 = flushCnt;
      vsyncPulse();
      check("rnd_capture", hdmiEn, 1);
      for (int l = 0; l < V; l++) begin
        len   = $urandom_range(H - 1, H + 1);
        ovfAt = (l == ovfLine) ? int'($urandom_range(0, len - 1)) : -1;
        sendLine(len, ovfAt, eo);
        if (l == ovfLine) check("rnd_overflowEnableDrop", eo, 0);
        if (ovfLine < 0 || l < ovfLine) expErr = expErr | (len != H);
        gap();
      end
      if (ovfLine >= 0) begin
        expOvf = 1'b1;
        check("rnd_noDone", doneCnt, d0);
        vsyncPulse();
        tick();
        check("rnd_flushOnce", flushCnt, f0 + 1);
        gap();
      end else begin
        check("rnd_doneOnce", doneCnt, d0 + 1);
        check("rnd_lineCount", lcnt, V);
        check("rnd_noFlush", flushCnt, f0);
      end
      check("rnd_lineError", lerr, expErr);
      check("rnd_overflow", ovf, expOvf);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hdmi_capture_ctrl.md
Name: hdmi_capture_ctrl

Overview:
Frame-level sequencer for the HDMI capture path, in the TFP401 pixel-clock domain, sitting between the TFP401 sync/DE pins, the 24→32-bit ingester and the pixel FIFO.
- Arms capture on software enable.
- Gates the ingester enable so only whole frames enter the FIFO.
- Checks line/frame geometry.
- On FIFO overflow, aborts the frame, requests a FIFO flush and re-arms at the next vSync.

Parameters:
H_ACTIVE, 800, active pixels per line; must be a multiple of 4 so the 4-pixel/3-word packing realigns at every line end.
V_ACTIVE, 480, active lines per frame.
CNT_W, 12, width of pixel and line counters.
VSYNC_POL, 0, vSync active level (0 = active-low).

Ports:
i_hdmiClock  in  1  pixel clock; all logic on rising edge.
i_reset  in  1  asynchronous, active-high reset.
i_captureEnable  in  1  level; software request to capture frames continuously.
i_vSync  in  1  TFP401 vSync.
i_hSync  in  1  TFP401 hSync; used only by the optional feature.
i_de  in  1  TFP401 data enable; high during active pixels.
i_fifoFull  in  1  pixel FIFO full.
i_dataValid  in  1  ingester word-valid strobe.
o_hdmiEnable  out  1  ingester enable.
o_fifoFlush  out  1  one-cycle FIFO flush request.
o_frameActive  out  1  high while in CAPTURE.
o_frameDone  out  1  one-cycle pulse on a clean frame completion.
o_overflow  out  1  sticky; FIFO overflowed.
o_lineError  out  1  sticky; a line length differed from H_ACTIVE.
o_lineCount  out  CNT_W  lines completed in the current frame.

Behaviour:
- Reset values: state IDLE; all outputs 0; counters 0; edge registers 0.
- Input registering: i_vSync and i_de are registered once (r_vSyncPrev, r_dePrev) for edge detection.
  - vSync trailing edge = transition from the active level to the inactive level.
  - DE falling edge = r_dePrev=1 and i_de=0.
- States:
  - IDLE: if i_captureEnable=1, go to WAIT_VSYNC.
  - WAIT_VSYNC: on vSync trailing edge, go to CAPTURE and clear the counters. If i_captureEnable=0, go to IDLE.
  - CAPTURE:
    - o_hdmiEnable=1 and o_frameActive=1, both registered, so they assert the cycle after the edge.
    - The pixel counter increments on each i_de=1 cycle and saturates at all-ones.
    - On a DE falling edge: if pixelCount≠H_ACTIVE, set o_lineError. Then clear the pixel counter and increment o_lineCount.
    - When o_lineCount reaches V_ACTIVE: pulse o_frameDone, then go to WAIT_VSYNC if i_captureEnable=1, else IDLE.
  - ERROR:
    - Entered when i_fifoFull=1 and i_dataValid=1 in CAPTURE.
    - o_hdmiEnable drops next cycle and o_overflow sets.
    - Waits for vSync trailing edge, then pulses o_fifoFlush for one cycle and goes to WAIT_VSYNC (or IDLE if disabled).
- i_captureEnable dropping mid-CAPTURE: the current frame completes normally, then the block goes to IDLE. No partial frames enter the FIFO.
- Overflow and final line end in the same cycle: overflow wins; no o_frameDone; ERROR entered.
- vSync edge seen during CAPTURE before V_ACTIVE lines: set o_lineError, abort the frame, pulse o_fifoFlush and restart in CAPTURE directly (the edge is the new frame start).
- Sticky flags clear only on reset, or on the i_captureEnable rising edge.
- Asynchronous reset mid-frame: outputs drop immediately. The FIFO is not flushed by this block; the system reset covers it.

Optional Feature:
HDMI_CAPTURE_STATS_EN:
- Defined: adds outputs o_frameCount[15:0] (clean frames, wraps) and o_droppedFrames[15:0] (ERROR entries plus aborted frames, saturating), plus o_hSyncPerFrame[CNT_W-1:0], the hSync rising edges counted over the last frame and latched at frameDone.
- Undefined: these ports and their counters are absent; core behaviour is identical.

Decomposition:
- Package hdmi_capture_pkg holds:
  - state encoding (IDLE=0, WAIT_VSYNC=1, CAPTURE=2, ERROR=3);
  - default resolution constants;
  - the CNT_W default.
- One sub-module, sync_edge_detect: a one-register edge detector instantiated for vSync, DE and (optionally) hSync, with a polarity parameter.

Test Plan:
1. Enable=1, 4×2 frame (H_ACTIVE=4, V_ACTIVE=2) after vSync trailing edge → o_hdmiEnable high 1 cycle after edge, lineCount 1 then 2, o_frameDone single pulse, state WAIT_VSYNC.
2. Line of 5 pixels with H_ACTIVE=4 → o_lineError=1 after that DE falling edge, frame still completes, flag held.
3. i_fifoFull=1 with i_dataValid=1 on line 1 → o_hdmiEnable=0 next cycle, o_overflow=1, no frameDone; at next vSync edge o_fifoFlush pulses once.
4. Deassert enable mid-frame → remaining lines captured, o_frameDone pulses, then IDLE with o_hdmiEnable=0.
5. Assert i_reset mid-CAPTURE → all outputs 0 immediately (asynchronous), IDLE after release.
6. Early vSync edge at line 1 of V_ACTIVE=2 → o_lineError=1, o_fifoFlush pulse, counters cleared, CAPTURE continues.
